// File: rtl/reg_file_param.sv
// reg_file_param: parametrised MIPS-style register file with two async read
// ports, one sync write port, hard-wired zero register, bypass and clear sweep.
module reg_file_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS    = 1,
  parameter int CHECK_IDX = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              RegWrite,
  input  logic              clear_req,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] check,
  output logic              busy,
  output logic              clr_done
);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_e;

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              busy_q;
  logic              clr_done_q;

  logic              rd_ok;
  logic              wr_en;
  logic              sweep;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  assign sweep = (state_q == SWEEP);
  assign rd_ok = (rd != '0) && (int'(rd) < NUM_REGS);
  assign wr_en = RegWrite && rd_ok && !sweep;
  assign ptr_d = ptr_q + 1'b1;

  assign raddr[0] = rs;
  assign raddr[1] = rt;

  // Register 0 and out-of-range addresses never reach the array or bypass.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      if (raddr[p] != '0 && int'(raddr[p]) < NUM_REGS) begin
        rdata[p] = regs_q[raddr[p][IW-1:0]];
        if (BYPASS != 0 && wr_en && rd == raddr[p]) begin
          rdata[p] = in_data;
        end
      end
    end
  end

  assign out_data1 = rdata[0];
  assign out_data2 = rdata[1];
  assign check     = regs_q[CHECK_IDX];
  assign busy      = busy_q;
  assign clr_done  = clr_done_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (sweep) begin
      regs_q[ptr_q[IW-1:0]] <= '0;
    end else if (wr_en) begin
      regs_q[rd[IW-1:0]] <= in_data;
    end
  end

  // clr_done is raised on the edge that makes the last sweep cycle current.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= FIRST;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q    <= SWEEP;
            ptr_q      <= FIRST;
            busy_q     <= 1'b1;
            clr_done_q <= (FIRST == LAST);
          end
        end
        SWEEP: begin
          if (ptr_q == LAST) begin
            state_q    <= IDLE;
            ptr_q      <= FIRST;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
          end else begin
            ptr_q      <= ptr_d;
            clr_done_q <= (ptr_d == LAST);
          end
        end
        default: begin
          state_q    <= IDLE;
          ptr_q      <= FIRST;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: randomized bench for reg_file_param, comparing a
// bypassing and a non-bypassing instance against an array reference model.
module tb_reg_file_param;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [AW-1:0] rs = '0;
  logic [AW-1:0] rt = '0;
  logic [AW-1:0] rd = '0;
  logic [DW-1:0] in_data = '0;
  logic          RegWrite = 1'b0;
  logic          clear_req = 1'b0;

  logic [DW-1:0] o1, o2, chk;
  logic          bsy, dn;
  logic [DW-1:0] o1n, o2n, chkn;
  logic          bsyn, dnn;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_regs [NR];
  int            m_cnt = 0;

  reg_file_param #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .BYPASS(1), .CHECK_IDX(1)
  ) dut (
    .CLK(CLK), .RST(RST), .rs(rs), .rt(rt), .rd(rd),
    .in_data(in_data), .RegWrite(RegWrite), .clear_req(clear_req),
    .out_data1(o1), .out_data2(o2), .check(chk),
    .busy(bsy), .clr_done(dn)
  );

  reg_file_param #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .BYPASS(0), .CHECK_IDX(1)
  ) dut_nb (
    .CLK(CLK), .RST(RST), .rs(rs), .rt(rt), .rd(rd),
    .in_data(in_data), .RegWrite(RegWrite), .clear_req(clear_req),
    .out_data1(o1n), .out_data2(o2n), .check(chkn),
    .busy(bsyn), .clr_done(dnn)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] exp_rd(input int a, input bit byp);
    if (a == 0 || a >= NR) return '0;
    if (byp && m_cnt == 0 && RegWrite && int'(rd) == a) return in_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_cnt = 0;
  endtask

  // Advance one clock: the model applies what the inputs held at the edge.
  task automatic tick();
    @(posedge CLK);
    if (m_cnt != 0) begin
      m_regs[NR - m_cnt] = '0;
      m_cnt--;
    end else begin
      if (RegWrite && rd != 0 && int'(rd) < NR) m_regs[rd] = in_data;
      if (clear_req) m_cnt = NR - 1;
    end
    #1;
  endtask

  task automatic fill_regs(input bit by_index);
    RegWrite = 1'b1;
    for (int i = 1; i < NR; i++) begin
      rd = AW'(i);
      in_data = by_index ? DW'(i) : $urandom;
      tick();
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #2;
    model_reset();
    rs = 6'd1; rt = 6'd31;
    #1;
    n_tests++; if (o1 !== '0) begin n_fail++; $display("FAIL rst_o1: got %h want 0", o1); end
    n_tests++; if (o2 !== '0) begin n_fail++; $display("FAIL rst_o2: got %h want 0", o2); end
    n_tests++; if (chk !== '0) begin n_fail++; $display("FAIL rst_chk: got %h want 0", chk); end
    n_tests++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bsy); end
    n_tests++; if (dn !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", dn); end
    @(negedge CLK);
    RST = 1'b0;
    fill_regs(1'b0);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    n_tests++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL rst2_busy: got %b want 0", bsy); end
    n_tests++; if (chk !== '0) begin n_fail++; $display("FAIL rst2_chk: got %h want 0", chk); end
    for (int a = 0; a < NR; a++) begin
      rs = AW'(a); rt = AW'(NR - 1 - a);
      #1;
      n_tests++;
      if (o1 !== '0 || o2 !== '0 || o1n !== '0) begin
        n_fail++;
        $display("FAIL rst2_rd[%0d]: got %h/%h/%h want 0", a, o1, o2, o1n);
      end
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  task automatic test_write_read();
    @(posedge CLK); #1;
    RegWrite = 1'b1; rd = 6'd5; in_data = 32'hDEADBEEF; rs = 6'd0; rt = 6'd0;
    tick();
    RegWrite = 1'b0; rs = 6'd5;
    #2;
    n_tests++; if (o1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr5: got %h want deadbeef", o1); end
    RegWrite = 1'b1; rd = 6'd0; in_data = 32'h1234; rs = 6'd0;
    #2;
    n_tests++; if (o1 !== '0) begin n_fail++; $display("FAIL r0_byp: got %h want 0", o1); end
    tick();
    RegWrite = 1'b0;
    #2;
    n_tests++; if (o1 !== '0) begin n_fail++; $display("FAIL r0: got %h want 0", o1); end
    RegWrite = 1'b1; rd = 6'd40; in_data = 32'h5555AAAA; rs = 6'd40; rt = 6'd40;
    #2;
    n_tests++; if (o1 !== '0) begin n_fail++; $display("FAIL oor_byp: got %h want 0", o1); end
    tick();
    RegWrite = 1'b0;
    #2;
    n_tests++; if (o2 !== '0) begin n_fail++; $display("FAIL oor: got %h want 0", o2); end
    for (int k = 0; k < 200; k++) begin
      rs = AW'($urandom_range(0, 63));
      rt = AW'($urandom_range(0, 63));
      rd = ($urandom_range(0, 3) == 0) ? rs : AW'($urandom_range(0, 63));
      RegWrite = 1'($urandom);
      in_data = $urandom;
      #2;
      n_tests++;
      if (o1 !== exp_rd(int'(rs), 1'b1) || o2 !== exp_rd(int'(rt), 1'b1)) begin
        n_fail++;
        $display("FAIL rnd_byp[%0d]: got %h/%h want %h/%h", k, o1, o2,
                 exp_rd(int'(rs), 1'b1), exp_rd(int'(rt), 1'b1));
      end
      n_tests++;
      if (o1n !== exp_rd(int'(rs), 1'b0) || o2n !== exp_rd(int'(rt), 1'b0)) begin
        n_fail++;
        $display("FAIL rnd_nb[%0d]: got %h/%h want %h/%h", k, o1n, o2n,
                 exp_rd(int'(rs), 1'b0), exp_rd(int'(rt), 1'b0));
      end
      n_tests++;
      if (chk !== m_regs[1]) begin
        n_fail++; $display("FAIL rnd_chk[%0d]: got %h want %h", k, chk, m_regs[1]);
      end
      tick();
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_bypass();
    RegWrite = 1'b1; rd = 6'd7; in_data = 32'h11111111;
    tick();
    rs = 6'd7; rt = 6'd7; in_data = 32'hA5A5A5A5;
    #2;
    n_tests++;
    if (o1 !== 32'hA5A5A5A5 || o2 !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL byp: got %h/%h want a5a5a5a5", o1, o2);
    end
    n_tests++;
    if (o1n !== 32'h11111111 || o2n !== 32'h11111111) begin
      n_fail++; $display("FAIL nobyp_old: got %h/%h want 11111111", o1n, o2n);
    end
    tick();
    RegWrite = 1'b0;
    #2;
    n_tests++;
    if (o1n !== 32'hA5A5A5A5 || o2n !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL nobyp_new: got %h/%h want a5a5a5a5", o1n, o2n);
    end
  endtask

  task automatic test_sweep();
    int busy_cyc;
    int pulses;
    int done_at;
    fill_regs(1'b1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cyc = 0; pulses = 0; done_at = -1;
    for (int c = 1; c <= 35; c++) begin
      RegWrite = 1'b0; rs = AW'(c % NR); rt = 6'd3;
      if (c == 10) begin RegWrite = 1'b1; rd = 6'd3; in_data = 32'hBAD0BAD0; end
      if (c == 12) begin RegWrite = 1'b1; rd = 6'd25; in_data = 32'hBAD1BAD1; rs = 6'd25; end
      clear_req = (c == 15);
      #2;
      if (bsy === 1'b1) busy_cyc++;
      if (dn === 1'b1) begin pulses++; done_at = c; end
      n_tests++;
      if (bsy !== (m_cnt != 0) || dn !== (m_cnt == 1)) begin
        n_fail++; $display("FAIL sw_flags[%0d]: got %b%b want %b%b", c, bsy, dn, m_cnt != 0, m_cnt == 1);
      end
      n_tests++;
      if (o1 !== exp_rd(int'(rs), 1'b1) || o2 !== exp_rd(int'(rt), 1'b1)) begin
        n_fail++; $display("FAIL sw_rd[%0d]: got %h/%h want %h/%h", c, o1, o2,
                           exp_rd(int'(rs), 1'b1), exp_rd(int'(rt), 1'b1));
      end
      tick();
    end
    RegWrite = 1'b0; clear_req = 1'b0;
    n_tests++; if (busy_cyc != NR - 1) begin n_fail++; $display("FAIL sw_len: got %0d want %0d", busy_cyc, NR - 1); end
    n_tests++; if (pulses != 1 || done_at != NR - 1) begin
      n_fail++; $display("FAIL sw_done: got %0d@%0d want 1@%0d", pulses, done_at, NR - 1);
    end
    for (int a = 0; a < NR; a++) begin
      rs = AW'(a); rt = AW'(a);
      #1;
      n_tests++;
      if (o1 !== '0 || o2n !== '0) begin n_fail++; $display("FAIL sw_clr[%0d]: got %h/%h want 0", a, o1, o2n); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cyc;
    @(posedge CLK); #1;
    fill_regs(1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    n_tests++; if (bsy !== 1'b0 || dn !== 1'b0) begin n_fail++; $display("FAIL msr_flags: got %b%b want 00", bsy, dn); end
    for (int a = 0; a < NR; a++) begin
      rs = AW'(a); rt = AW'(a);
      #1;
      n_tests++;
      if (o1 !== '0 || o2 !== '0) begin n_fail++; $display("FAIL msr_rd[%0d]: got %h/%h want 0", a, o1, o2); end
    end
    @(negedge CLK);
    RST = 1'b0;
    RegWrite = 1'b1; rd = 6'd31; in_data = $urandom | 32'h1;
    tick();
    RegWrite = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cyc = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      n_tests++;
      if (bsy !== (m_cnt != 0) || dn !== (m_cnt == 1)) begin
        n_fail++; $display("FAIL msr_sw[%0d]: got %b%b want %b%b", c, bsy, dn, m_cnt != 0, m_cnt == 1);
      end
      if (bsy !== 1'b1) break;
      busy_cyc++;
      tick();
    end
    n_tests++; if (busy_cyc != NR - 1) begin n_fail++; $display("FAIL msr_len: got %0d want %0d", busy_cyc, NR - 1); end
    rs = 6'd31;
    #1;
    n_tests++; if (o1 !== '0) begin n_fail++; $display("FAIL msr_r31: got %h want 0", o1); end
  endtask

  task automatic test_check();
    logic [DW-1:0] v;
    @(posedge CLK); #1;
    RegWrite = 1'b1; rd = 6'd1; in_data = 32'h00000042; rs = 6'd2; rt = 6'd2;
    #2;
    n_tests++; if (chk !== m_regs[1]) begin n_fail++; $display("FAIL chk_early: got %h want %h", chk, m_regs[1]); end
    tick();
    RegWrite = 1'b0;
    #2;
    n_tests++; if (chk !== 32'h42) begin n_fail++; $display("FAIL chk_wr: got %h want 00000042", chk); end
    v = $urandom | 32'h100;
    RegWrite = 1'b1; in_data = v; rs = 6'd1; rt = 6'd1;
    #2;
    n_tests++;
    if (o1 !== v || o2 !== v || chk !== 32'h42 || chkn !== 32'h42) begin
      n_fail++; $display("FAIL chk_byp: got %h/%h/%h want %h/%h/00000042", o1, o2, chk, v, v);
    end
    tick();
    RegWrite = 1'b0;
    #2;
    n_tests++; if (chk !== v) begin n_fail++; $display("FAIL chk_next: got %h want %h", chk, v); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_sweep();
    test_reset_mid_sweep();
    test_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
